seg_display_driver: RTL and testbench

- Successor to the calculator's 7-segment shift-register output driver. It accepts a magnitude, a sign, an error flag, a decimal-point mask and a hex/decimal mode through a valid/ready handshake.
- Decimal mode converts the magnitude to BCD sequentially (double-dabble).
- It serially shifts 8 bits per display (a..g, dp) into chained 74HC595-style registers, using a registered, divided shift clock and a latch pulse.
- It sits between the calculator core and the board's display chain.

---
 rtl/seg_display_driver.sv | 189 ++++++++++++++++++
 tb/tb_seg_display_driver.sv | 138 +++++++++++++
 2 files changed

// File: rtl/seg_display_driver.sv
// Serial 7-segment chain driver: hex or decimal (double-dabble) digits, sign, Err and dp,
// shifted MSB-display-first into 74HC595-style registers with a divided shift clock and latch.
module seg_display_driver #(
  parameter int DATA_WIDTH            = 16,
  parameter int NUM_DISPLAYS          = 5,
  parameter int SR_CLK_DIV            = 1,
  parameter bit SEG_ACTIVE_LOW        = 1'b0,
  parameter bit OE_BLANK_DURING_SHIFT = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_data_is_neg,
  input  logic                    i_error,
  input  logic                    i_decimal,
  input  logic [NUM_DISPLAYS-1:0] i_dp_mask,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic                    o_sr_data,
  output logic                    o_sr_clk,
  output logic                    o_sr_latch,
  output logic                    o_sr_oe_n
);
  localparam int NBCD  = (DATA_WIDTH * 30103) / 100000 + 1;
  localparam int NHEX  = DATA_WIDTH / 4;
  localparam int NMAX0 = (NBCD > NHEX) ? NBCD : NHEX;
  localparam int NDIG  = (NMAX0 > NUM_DISPLAYS) ? NMAX0 : NUM_DISPLAYS;
  localparam int NBITS = NUM_DISPLAYS * 8;
  localparam int DIVW  = $clog2(SR_CLK_DIV + 1);
  localparam int BITW  = $clog2(NBITS);
  localparam int CNTW  = $clog2(DATA_WIDTH + 1);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SR_CLK_DIV - 1);
  localparam logic [BITW-1:0] BIT_LAST = BITW'(NBITS - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_SHIFT, S_LATCH} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1111110;  4'h1: seg7 = 7'b0110000;
      4'h2: seg7 = 7'b1101101;  4'h3: seg7 = 7'b1111001;
      4'h4: seg7 = 7'b0110011;  4'h5: seg7 = 7'b1011011;
      4'h6: seg7 = 7'b1011111;  4'h7: seg7 = 7'b1110000;
      4'h8: seg7 = 7'b1111111;  4'h9: seg7 = 7'b1111011;
      4'hA: seg7 = 7'b1110111;  4'hB: seg7 = 7'b0011111;
      4'hC: seg7 = 7'b1001110;  4'hD: seg7 = 7'b0111101;
      4'hE: seg7 = 7'b1001111;  default: seg7 = 7'b1000111;
    endcase
  endfunction

  // Whole chain image, display NUM_DISPLAYS-1 in the top byte, a..g,dp from bit 7 down.
  function automatic logic [NBITS-1:0] frame_f(input logic [NDIG*4-1:0] dig, input logic neg,
                                               input logic err, input logic [NUM_DISPLAYS-1:0] mask);
    logic [NBITS-1:0] f;
    logic [7:0]       b;
    logic             bad;
    int               h;
    h = 0; bad = err; f = '0;
    for (int k = 0; k < NDIG; k++)
      if (dig[k*4 +: 4] != 4'd0) begin
        h = k;
        if (k >= NUM_DISPLAYS) bad = 1'b1;
      end
    if (neg && h == NUM_DISPLAYS - 1) bad = 1'b1;
    for (int i = 0; i < NUM_DISPLAYS; i++) begin
      b = 8'h00;
      if (bad) begin
        if (i == 2)     b = {7'b1001111, 1'b0};
        else if (i < 2) b = {7'b0000101, 1'b0};
      end else begin
        if (i <= h)                b[7:1] = seg7(dig[i*4 +: 4]);
        else if (neg && i == h + 1) b[7:1] = 7'b0000001;
        b[0] = mask[i];
      end
      f[i*8 +: 8] = b ^ {8{SEG_ACTIVE_LOW}};
    end
    return f;
  endfunction

  state_t                  r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_bin;
  logic [NBCD*4-1:0]       r_bcd, w_bcd_adj, w_bcd_nxt;
  logic                    r_neg;
  logic [NUM_DISPLAYS-1:0] r_mask;
  logic [CNTW-1:0]         r_cnt;
  logic [DIVW-1:0]         r_div;
  logic [BITW-1:0]         r_bit;
  logic [NBITS-1:0]        r_frame, w_nframe;
  logic [NDIG*4-1:0]       w_src_dig;
  logic                    r_ready, r_sr_data, r_sr_clk, r_sr_latch, r_sr_oe_n;
  logic                    w_div_end;

  assign o_ready    = r_ready;
  assign o_sr_data  = r_sr_data;
  assign o_sr_clk   = r_sr_clk;
  assign o_sr_latch = r_sr_latch;
  assign o_sr_oe_n  = r_sr_oe_n;
  assign w_div_end  = (r_div == DIV_LAST);

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < NBCD; k++)
      if (r_bcd[k*4 +: 4] >= 4'd5) w_bcd_adj[k*4 +: 4] = r_bcd[k*4 +: 4] + 4'd3;
    w_bcd_nxt = {w_bcd_adj[NBCD*4-2:0], r_bin[DATA_WIDTH-1]};
  end

  // The frame is built from next-cycle sources so the first bit is on o_sr_data at SHIFT entry.
  always_comb begin
    w_src_dig = '0;
    if (r_state == S_CONVERT) begin
      w_src_dig[NBCD*4-1:0] = w_bcd_nxt;
      w_nframe = frame_f(w_src_dig, r_neg, 1'b0, r_mask);
    end else begin
      w_src_dig[DATA_WIDTH-1:0] = i_data;
      w_nframe = frame_f(w_src_dig, i_data_is_neg, i_error, i_dp_mask);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_valid) w_state_nxt = (i_decimal && !i_error) ? S_CONVERT : S_SHIFT;
      S_CONVERT: if (r_cnt == CNT_LAST) w_state_nxt = S_SHIFT;
      S_SHIFT:   if (w_div_end && r_sr_clk && r_bit == BIT_LAST) w_state_nxt = S_LATCH;
      default:   if (w_div_end) w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_SHIFT;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_neg      <= 1'b0;
      r_mask     <= '0;
      r_cnt      <= '0;
      r_div      <= '0;
      r_bit      <= '0;
      r_frame    <= frame_f('0, 1'b0, 1'b0, '0);
      r_ready    <= 1'b0;
      r_sr_data  <= 1'b0;
      r_sr_clk   <= 1'b0;
      r_sr_latch <= 1'b0;
      r_sr_oe_n  <= OE_BLANK_DURING_SHIFT;
    end else begin
      r_state    <= w_state_nxt;
      r_ready    <= (w_state_nxt == S_IDLE);
      r_sr_latch <= (w_state_nxt == S_LATCH);
      r_sr_oe_n  <= OE_BLANK_DURING_SHIFT && (w_state_nxt != S_IDLE);
      if ((r_state == S_IDLE || r_state == S_CONVERT) && w_state_nxt == S_SHIFT) begin
        r_frame   <= w_nframe;
        r_sr_data <= w_nframe[NBITS-1];
        r_bit     <= '0;
        r_div     <= '0;
        r_sr_clk  <= 1'b0;
      end
      case (r_state)
        S_IDLE: if (i_valid) begin
          r_bin  <= i_data;
          r_bcd  <= '0;
          r_neg  <= i_data_is_neg;
          r_mask <= i_dp_mask;
          r_cnt  <= '0;
        end
        S_CONVERT: begin
          r_bcd <= w_bcd_nxt;
          r_bin <= {r_bin[DATA_WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
        end
        S_SHIFT: begin
          // Data is (re)driven only while the shift clock is low; it advances at high->low.
          if (!r_sr_clk) r_sr_data <= r_frame[NBITS-1];
          if (w_div_end) begin
            r_div    <= '0;
            r_sr_clk <= ~r_sr_clk;
            if (r_sr_clk && r_bit != BIT_LAST) begin
              r_bit     <= r_bit + 1'b1;
              r_frame   <= {r_frame[NBITS-2:0], 1'b0};
              r_sr_data <= r_frame[NBITS-2];
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: r_div <= w_div_end ? '0 : r_div + 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench: two driver instances (default, and active-low with /3 shift clock);
// frames are captured on o_sr_clk rising edges and compared with hand-computed images.
module tb_seg_display_driver;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst1_n, vld0, vld1;
  logic [15:0] data;
  logic        neg, err, dec;
  logic [4:0]  mask;
  logic        rdy0, sd0, sc0, sl0, oe0;
  logic        rdy1, sd1, sc1, sl1, oe1;
  logic        sel;

  seg_display_driver u0 (
    .clk(clk), .rst_n(rst0_n), .i_data(data), .i_data_is_neg(neg), .i_error(err),
    .i_decimal(dec), .i_dp_mask(mask), .i_valid(vld0), .o_ready(rdy0),
    .o_sr_data(sd0), .o_sr_clk(sc0), .o_sr_latch(sl0), .o_sr_oe_n(oe0));

  seg_display_driver #(.SR_CLK_DIV(3), .SEG_ACTIVE_LOW(1'b1)) u1 (
    .clk(clk), .rst_n(rst1_n), .i_data(data), .i_data_is_neg(neg), .i_error(err),
    .i_decimal(dec), .i_dp_mask(mask), .i_valid(vld1), .o_ready(rdy1),
    .o_sr_data(sd1), .o_sr_clk(sc1), .o_sr_latch(sl1), .o_sr_oe_n(oe1));

  wire m_rdy = sel ? rdy1 : rdy0;
  wire m_dat = sel ? sd1  : sd0;
  wire m_clk = sel ? sc1  : sc0;
  wire m_lat = sel ? sl1  : sl0;
  wire m_oe  = sel ? oe1  : oe0;

  int n_tot = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic collect(output logic [39:0] bits, output int busy, output int first,
                         output int per, output int nlat, output int nrise, output int oe_bad);
    logic pc;
    bits = '0; busy = 0; first = -1; per = -1; nlat = 0; nrise = 0; oe_bad = 0; pc = 1'b0;
    while (!m_rdy && busy < 3000) begin
      if (m_clk && !pc) begin
        bits = {bits[38:0], m_dat};
        nrise++;
        if (first < 0) first = busy;
        else if (per < 0) per = busy - first;
      end
      if (m_lat) nlat++;
      if (!m_oe) oe_bad++;
      pc = m_clk;
      busy++;
      @(negedge clk);
    end
    if (busy >= 3000) chk("timeout", 64'(m_rdy), 64'd1);
  endtask

  task automatic xfer(input string tag, input logic [39:0] exp_bits, input int exp_busy,
                      input int exp_first);
    logic [39:0] bits;
    int busy, first, per, nlat, nrise, oe_bad;
    collect(bits, busy, first, per, nlat, nrise, oe_bad);
    chk({tag, ".bits"},  64'(bits),   64'(exp_bits));
    chk({tag, ".busy"},  64'(busy),   64'(exp_busy));
    chk({tag, ".first"}, 64'(first),  64'(exp_first));
    chk({tag, ".per"},   64'(per),    sel ? 64'd6 : 64'd2);
    chk({tag, ".nrise"}, 64'(nrise),  64'd40);
    chk({tag, ".nlat"},  64'(nlat),   sel ? 64'd3 : 64'd1);
    chk({tag, ".oebsy"}, 64'(oe_bad), 64'd0);
    chk({tag, ".oeidl"}, 64'(m_oe),   64'd0);
  endtask

  task automatic send(input logic [15:0] d, input logic n, input logic e, input logic dc,
                      input logic [4:0] m, input bit keep);
    @(negedge clk);
    data = d; neg = n; err = e; dec = dc; mask = m;
    if (sel) vld1 = 1'b1; else vld0 = 1'b1;
    @(negedge clk);
    if (!keep) begin vld0 = 1'b0; vld1 = 1'b0; end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".rdy"}, 64'(m_rdy), 64'd0);
    chk({tag, ".dat"}, 64'(m_dat), 64'd0);
    chk({tag, ".clk"}, 64'(m_clk), 64'd0);
    chk({tag, ".lat"}, 64'(m_lat), 64'd0);
    chk({tag, ".oe"},  64'(m_oe),  64'd1);
  endtask

  initial begin
    sel = 1'b0; rst0_n = 1'b0; rst1_n = 1'b0; vld0 = 1'b0; vld1 = 1'b0;
    data = '0; neg = 1'b0; err = 1'b0; dec = 1'b0; mask = '0;
    repeat (3) @(negedge clk);
    chk_rst("rst0");
    rst0_n = 1'b1;
    xfer("por",      40'h00000000FC, 81, 1);
    send(16'h00A3, 1'b0, 1'b0, 1'b0, 5'b00010, 1'b0);
    xfer("hexA3",    40'h000000EFF2, 81, 1);
    send(16'd1234, 1'b1, 1'b0, 1'b1, 5'b00000, 1'b0);
    xfer("dec1234",  40'h0260DAF266, 97, 17);
    send(16'd65535, 1'b0, 1'b0, 1'b1, 5'b00000, 1'b0);
    xfer("dec65535", 40'hBEB6B6F2B6, 97, 17);
    send(16'd65535, 1'b1, 1'b0, 1'b1, 5'b00000, 1'b0);
    xfer("neg65535", 40'h00009E0A0A, 97, 17);
    send(16'h0000, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0);
    xfer("negzero",  40'h00000002FC, 81, 1);
    send(16'hFFFF, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0);
    xfer("negFFFF",  40'h028E8E8E8E, 81, 1);
    send(16'd0, 1'b0, 1'b0, 1'b1, 5'b11111, 1'b0);
    xfer("dpall",    40'h01010101FD, 97, 17);
    send(16'h1234, 1'b0, 1'b1, 1'b1, 5'b11111, 1'b1);
    xfer("err",      40'h00009E0A0A, 81, 1);
    vld0 = 1'b0;
    @(negedge clk);
    chk("err.onecap", 64'(rdy0), 64'd1);

    sel = 1'b1;
    repeat (2) @(negedge clk);
    chk_rst("rst1");
    rst1_n = 1'b1;
    xfer("por1",  40'hFFFFFFFF03, 243, 3);
    send(16'h0001, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0);
    xfer("hex1",  40'hFFFFFFFF9F, 243, 3);
    send(16'h0001, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0);
    repeat (50) @(negedge clk);
    rst1_n = 1'b0;
    @(negedge clk);
    chk_rst("midrst");
    rst1_n = 1'b1;
    xfer("por1b", 40'hFFFFFFFF03, 243, 3);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
